// File: rtl/sblk_act_feeder.sv
`default_nettype none
// +-----------------------------------------------------------------------------------------+
// | Module   : sblk_act_feeder                                                              |
// | Brief    : Broadcasts per-row instructions and demuxes a tagged activation stream into  |
// |            per-row FIFOs drained over each row's vld/req handshake; signals job_done.   |
// |            Optional macro SBLK_ACT_FEEDER_PERF_EN adds the perf_stall_cyc counter.      |
// | Revision : 1.0 - initial release                                                        |
// +-----------------------------------------------------------------------------------------+
module sblk_act_feeder #(
    parameter int N_ROW      = 3,
    parameter int WID_ACT    = 16,
    parameter int WID_INST   = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_CNT    = 16,
    parameter int WID_ROW    = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
    input  logic                          clk_l,
    input  logic                          rst_n,
    input  logic                          job_start,
    input  logic [WID_INST*N_ROW-1:0]     job_inst,
    input  logic [WID_CNT*N_ROW-1:0]      job_act_cnt,
    input  logic [2*WID_ACT-1:0]          s_data,
    input  logic [WID_ROW-1:0]            s_row,
    input  logic                          s_vld,
    output logic                          s_rdy,
    output logic [WID_INST*N_ROW-1:0]     inst_data,
    output logic [N_ROW-1:0]              inst_en,
    output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
    output logic [N_ROW-1:0]              act_data_in_vld,
    input  logic [N_ROW-1:0]              act_data_in_req,
    input  logic [N_ROW-1:0]              status_sblk,
    output logic                          job_busy,
    output logic                          job_done,
    output logic                          err_row
`ifdef SBLK_ACT_FEEDER_PERF_EN
    ,
    output logic [31:0]                   perf_stall_cyc
`endif
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_word_w = 2 * WID_ACT;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [WID_INST*N_ROW-1:0]   r_inst;
    logic                        r_err;
    logic                        w_start;
    logic                        w_row_ok;
    logic [N_ROW-1:0]            w_row_sel;
    logic [N_ROW-1:0]            w_can_take;
    logic [N_ROW-1:0]            w_push;
    logic [N_ROW-1:0]            w_pop;
    logic [N_ROW-1:0]            w_empty;
    logic [N_ROW-1:0]            w_full;
    logic [N_ROW-1:0]            w_acc_met;
    logic [N_ROW-1:0]            w_drained;

    assign w_start  = (r_state == S_IDLE) && job_start;
    // An out-of-range tag matches no row; such words are always taken and dropped.
    assign w_row_ok = |w_row_sel;
    assign s_rdy    = !w_row_ok || |(w_row_sel & w_can_take);

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        logic [c_word_w-1:0] r_mem [FIFO_DEPTH];
        logic [c_ptr_w-1:0]  r_wptr;
        logic [c_ptr_w-1:0]  r_rptr;
        logic [WID_CNT-1:0]  r_cnt;
        logic [WID_CNT-1:0]  r_acc;
        logic [WID_CNT-1:0]  r_dlv;

        assign w_empty[r]    = (r_wptr == r_rptr);
        assign w_full[r]     = (r_wptr[c_ptr_w-1] != r_rptr[c_ptr_w-1]) &&
                               (r_wptr[c_ptr_w-2:0] == r_rptr[c_ptr_w-2:0]);
        assign w_row_sel[r]  = (s_row == WID_ROW'(r));
        assign w_can_take[r] = (r_state == S_STREAM) && !w_full[r] && (r_acc < r_cnt);
        assign w_push[r]     = s_vld && w_row_sel[r] && w_can_take[r];
        assign w_pop[r]      = !w_empty[r] && act_data_in_req[r];
        assign w_acc_met[r]  = ((r_acc + WID_CNT'(w_push[r])) == r_cnt);
        assign w_drained[r]  = w_empty[r] && (r_dlv == r_cnt);

        assign act_data_in_vld[r]                    = w_pop[r];
        assign act_data_in[r*c_word_w +: c_word_w]   = r_mem[r_rptr[c_ptr_w-2:0]];

        always_ff @(posedge clk_l or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
                r_acc  <= '0;
                r_dlv  <= '0;
            end else if (w_start) begin
                r_cnt <= job_act_cnt[r*WID_CNT +: WID_CNT];
                r_acc <= '0;
                r_dlv <= '0;
            end else begin
                if (w_push[r]) begin
                    r_mem[r_wptr[c_ptr_w-2:0]] <= s_data;
                    r_wptr <= r_wptr + c_ptr_w'(1);
                    r_acc  <= r_acc + WID_CNT'(1);
                end
                if (w_pop[r]) begin
                    r_rptr <= r_rptr + c_ptr_w'(1);
                    r_dlv  <= r_dlv + WID_CNT'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_inst  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_inst <= job_inst;
            end
            if (s_vld && !w_row_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        job_done    = 1'b0;
        case (r_state)
            S_IDLE:   if (job_start) w_state_nxt = S_ISSUE;
            S_ISSUE:  w_state_nxt = S_STREAM;
            S_STREAM: if (&w_acc_met) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (&w_drained) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (status_sblk == '0) begin
                    w_state_nxt = S_IDLE;
                    job_done    = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign inst_data = r_inst;
    assign inst_en   = {N_ROW{r_state == S_ISSUE}};
    assign job_busy  = (r_state != S_IDLE);
    assign err_row   = r_err;

`ifdef SBLK_ACT_FEEDER_PERF_EN
    logic [31:0] r_perf;
    logic        w_stall;

    // A stall is a row that has data queued but is not requesting it.
    assign w_stall = ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                     (|(~w_empty & ~act_data_in_req));

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= '0;
        end else if (w_stall && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_cyc = r_perf;
`endif

endmodule
`default_nettype wire
